// File: rtl/axi4s_uart_pkg.sv
// axi4s_uart_pkg: shared types, constants and divider arithmetic for the configurable UART
package axi4s_uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  localparam int OVERSAMPLE = 16;
  localparam int TU_FRAME = 0;
  localparam int TU_PARITY = 1;
  localparam int TU_OVERRUN = 2;
  function automatic int ovs_div(input longint freq, input longint baud);
    return baud < 1 ? 0 : int'((freq + 8 * baud) / (OVERSAMPLE * baud));
  endfunction
endpackage

// File: rtl/axi4s_uart_tick.sv
// axi4s_uart_tick: free-running divider producing a one-cycle oversample tick
module axi4s_uart_tick #(
  parameter int DIV = 1
) (
  input  logic aclk,
  input  logic aresetn,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  // count 0..DIV-1 and wrap on the tick
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/axi4s_uart_cfg.sv
// axi4s_uart_cfg: AXI4-Stream UART with configurable data width, parity and stop bits
module axi4s_uart_cfg #(
  parameter int ACLK_FREQUENCY = 200000000,
  parameter int BAUD_RATE = 9600,
  parameter int BAUD_RATE_SIM = 50000000,
  parameter int SIM_MODE = 0,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  input  logic                 tx_byte_tvalid,
  output logic                 tx_byte_tready,
  input  logic [DATA_BITS-1:0] tx_byte_tdata,
  input  logic                 tx_byte_tkeep,
  output logic                 rx_byte_tvalid,
  input  logic                 rx_byte_tready,
  output logic [DATA_BITS-1:0] rx_byte_tdata,
  output logic [2:0]           rx_byte_tuser
);
  import axi4s_uart_pkg::*;
  localparam int DIV = ovs_div(ACLK_FREQUENCY, SIM_MODE != 0 ? BAUD_RATE_SIM : BAUD_RATE);
  localparam logic [3:0] LAST_T = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  localparam logic ODD = PARITY == int'(PAR_ODD);
  localparam logic HAS_PAR = PARITY != int'(PAR_NONE);
  if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("axi4s_uart_cfg: illegal parameter set");
  end
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_t;
  logic tick;
  axi4s_uart_tick #(.DIV(DIV)) u_tick (.aclk(aclk), .aresetn(aresetn), .tick(tick));
  tx_st_t tx_st, tx_st_n;
  logic [DATA_BITS:0] tx_sh, tx_sh_n;
  logic [3:0] tx_tc, tx_tc_n, tx_bc, tx_bc_n;
  logic tx_rdy, tx_txd_n, tx_end;
  assign tx_byte_tready = tx_rdy && tx_st == T_IDLE;
  assign tx_end = tick && tx_tc == LAST_T;
  // TX next state; the shift register carries the parity bit above the payload
  always_comb begin
    tx_st_n = tx_st;
    tx_sh_n = tx_sh;
    tx_tc_n = tx_tc;
    tx_bc_n = tx_bc;
    if (tick && tx_st != T_IDLE && tx_st != T_WAIT) tx_tc_n = tx_tc + 4'd1;
    case (tx_st)
      T_IDLE: if (tx_byte_tvalid && tx_byte_tready && tx_byte_tkeep) begin
        tx_sh_n = {(^tx_byte_tdata) ^ ODD, tx_byte_tdata};
        tx_tc_n = '0;
        tx_bc_n = '0;
        tx_st_n = tick ? T_START : T_WAIT;
      end
      T_WAIT: tx_st_n = tick ? T_START : T_WAIT;
      T_START: tx_st_n = tx_end ? T_DATA : T_START;
      T_DATA: if (tx_end) begin
        tx_sh_n = tx_sh >> 1;
        tx_bc_n = tx_bc == LAST_D ? 4'd0 : tx_bc + 4'd1;
        tx_st_n = tx_bc != LAST_D ? T_DATA : HAS_PAR ? T_PAR : T_STOP;
      end
      T_PAR: tx_st_n = tx_end ? T_STOP : T_PAR;
      T_STOP: if (tx_end) begin
        tx_bc_n = tx_bc + 4'd1;
        tx_st_n = tx_bc == LAST_S ? T_IDLE : T_STOP;
      end
      default: tx_st_n = T_IDLE;
    endcase
    tx_txd_n = tx_st_n == T_START ? 1'b0 : (tx_st_n == T_DATA || tx_st_n == T_PAR) ? tx_sh_n[0] : 1'b1;
  end
  // TX state register; the line output is registered so it never glitches
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      tx_st <= T_IDLE;
      tx_sh <= '0;
      tx_tc <= '0;
      tx_bc <= '0;
      tx_rdy <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      tx_st <= tx_st_n;
      tx_sh <= tx_sh_n;
      tx_tc <= tx_tc_n;
      tx_bc <= tx_bc_n;
      tx_rdy <= 1'b1;
      uart_txd <= tx_txd_n;
    end
  rx_st_t rx_st, rx_st_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic [3:0] rx_tc, rx_tc_n, rx_bc, rx_bc_n;
  logic [1:0] rx_smp, rx_smp_n;
  logic rx_m, rx_s, rx_p, rx_perr, rx_perr_n, rx_dec, rx_v, rx_end, rx_done, rx_ovr;
  assign rx_dec = tick && rx_tc == 4'd9;
  assign rx_end = tick && rx_tc == LAST_T;
  assign rx_v = (rx_smp[1] & rx_smp[0]) | (rx_smp[1] & rx_s) | (rx_smp[0] & rx_s);
  // synchronise the line and keep one extra stage for falling-edge detection
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) {rx_m, rx_s, rx_p} <= 3'b111;
    else {rx_m, rx_s, rx_p} <= {uart_rxd, rx_m, rx_s};
  // RX next state; samples at ticks 7 and 8 are voted with tick 9
  always_comb begin
    rx_st_n = rx_st;
    rx_sh_n = rx_sh;
    rx_tc_n = rx_tc;
    rx_bc_n = rx_bc;
    rx_perr_n = rx_perr;
    rx_done = 1'b0;
    rx_smp_n = tick && (rx_tc == 4'd7 || rx_tc == 4'd8) ? {rx_smp[0], rx_s} : rx_smp;
    if (tick && rx_st != R_IDLE) rx_tc_n = rx_tc + 4'd1;
    case (rx_st)
      R_IDLE: if (rx_p && !rx_s) begin
        rx_st_n = R_START;
        rx_tc_n = '0;
        rx_bc_n = '0;
        rx_perr_n = 1'b0;
      end
      R_START: rx_st_n = rx_dec && rx_v ? R_IDLE : rx_end ? R_DATA : R_START;
      R_DATA: begin
        if (rx_dec) rx_sh_n = {rx_v, rx_sh[DATA_BITS-1:1]};
        if (rx_end) begin
          rx_bc_n = rx_bc + 4'd1;
          rx_st_n = rx_bc != LAST_D ? R_DATA : HAS_PAR ? R_PAR : R_STOP;
        end
      end
      R_PAR: begin
        if (rx_dec) rx_perr_n = rx_v ^ (^rx_sh) ^ ODD;
        rx_st_n = rx_end ? R_STOP : R_PAR;
      end
      R_STOP: if (rx_dec) begin
        rx_done = 1'b1;
        rx_st_n = R_IDLE;
      end
      default: rx_st_n = R_IDLE;
    endcase
  end
  // RX state register
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rx_st <= R_IDLE;
      rx_sh <= '0;
      rx_tc <= '0;
      rx_bc <= '0;
      rx_smp <= 2'b11;
      rx_perr <= 1'b0;
    end else begin
      rx_st <= rx_st_n;
      rx_sh <= rx_sh_n;
      rx_tc <= rx_tc_n;
      rx_bc <= rx_bc_n;
      rx_smp <= rx_smp_n;
      rx_perr <= rx_perr_n;
    end
  // output holding register; a frame arriving while one is still held is dropped and flagged
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rx_byte_tvalid <= 1'b0;
      rx_byte_tdata <= '0;
      rx_byte_tuser <= '0;
      rx_ovr <= 1'b0;
    end else if (rx_done && (!rx_byte_tvalid || rx_byte_tready)) begin
      rx_byte_tvalid <= 1'b1;
      rx_byte_tdata <= rx_sh;
      rx_byte_tuser[TU_OVERRUN] <= rx_ovr;
      rx_byte_tuser[TU_PARITY] <= rx_perr;
      rx_byte_tuser[TU_FRAME] <= !rx_v;
      rx_ovr <= 1'b0;
    end else begin
      if (rx_done) rx_ovr <= 1'b1;
      if (rx_byte_tready) rx_byte_tvalid <= 1'b0;
    end
endmodule

// File: tb/tb_axi4s_uart_cfg.sv
// tb_axi4s_uart_cfg: randomized self-checking bench for three UART configurations
module tb_axi4s_uart_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aresetn = 1'b0;
  int total = 0;
  int bad = 0;
  logic a_txd, a_rxd = 1'b1, a_tvalid = 1'b0, a_tready, a_tkeep = 1'b1, a_rvalid, a_rready = 1'b0;
  logic [7:0] a_tdata = '0, a_rdata;
  logic [2:0] a_ruser;
  logic b_txd, b_tvalid = 1'b0, b_tready, b_tkeep = 1'b1, b_rvalid, b_rready = 1'b0;
  logic [6:0] b_tdata = '0, b_rdata;
  logic [2:0] b_ruser;
  logic c_txd, c_rxd = 1'b1, c_tvalid = 1'b0, c_tready, c_tkeep = 1'b0, c_rvalid, c_rready = 1'b0;
  logic [7:0] c_tdata = '0, c_rdata;
  logic [2:0] c_ruser;

  axi4s_uart_cfg #(.ACLK_FREQUENCY(1600000), .BAUD_RATE_SIM(100000), .SIM_MODE(1),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .aclk(clk), .aresetn(aresetn), .uart_txd(a_txd), .uart_rxd(a_rxd),
    .tx_byte_tvalid(a_tvalid), .tx_byte_tready(a_tready), .tx_byte_tdata(a_tdata), .tx_byte_tkeep(a_tkeep),
    .rx_byte_tvalid(a_rvalid), .rx_byte_tready(a_rready), .rx_byte_tdata(a_rdata), .rx_byte_tuser(a_ruser));
  axi4s_uart_cfg #(.ACLK_FREQUENCY(1600000), .BAUD_RATE_SIM(100000), .SIM_MODE(1),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
    .aclk(clk), .aresetn(aresetn), .uart_txd(b_txd), .uart_rxd(b_txd),
    .tx_byte_tvalid(b_tvalid), .tx_byte_tready(b_tready), .tx_byte_tdata(b_tdata), .tx_byte_tkeep(b_tkeep),
    .rx_byte_tvalid(b_rvalid), .rx_byte_tready(b_rready), .rx_byte_tdata(b_rdata), .rx_byte_tuser(b_ruser));
  axi4s_uart_cfg #(.ACLK_FREQUENCY(1600000), .BAUD_RATE_SIM(100000), .SIM_MODE(1),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .aclk(clk), .aresetn(aresetn), .uart_txd(c_txd), .uart_rxd(c_rxd),
    .tx_byte_tvalid(c_tvalid), .tx_byte_tready(c_tready), .tx_byte_tdata(c_tdata), .tx_byte_tkeep(c_tkeep),
    .rx_byte_tvalid(c_rvalid), .rx_byte_tready(c_rready), .rx_byte_tdata(c_rdata), .rx_byte_tuser(c_ruser));

  function automatic logic par_bit(input logic [8:0] d, input int nd, input int par);
    logic p;
    p = par == 2;
    for (int j = 0; j < nd; j++) p ^= d[j];
    return p;
  endfunction

  // sel 0 = 8N1 instance, sel 1 = 7E2 loopback instance
  task automatic test_tx(input int sel, input logic [8:0] d);
    int nd = sel != 0 ? 7 : 8;
    int par = sel != 0 ? 1 : 0;
    int ns = sel != 0 ? 2 : 1;
    int n = 0;
    logic q[$];
    q.push_back(1'b0);
    for (int j = 0; j < nd; j++) q.push_back(d[j]);
    if (par != 0) q.push_back(par_bit(d, nd, par));
    for (int j = 0; j < ns; j++) q.push_back(1'b1);
    @(negedge clk);
    if (sel != 0) begin b_tdata = d[6:0]; b_tkeep = 1'b1; b_tvalid = 1'b1; end
    else begin a_tdata = d[7:0]; a_tkeep = 1'b1; a_tvalid = 1'b1; end
    while (!(sel != 0 ? b_tready : a_tready) && n < 400) begin @(negedge clk); n++; end
    total++;
    if (n >= 400) begin bad++; $display("FAIL tx_ready_wait: dut=%0d tready stayed 0, required 1", sel); end
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    for (int i = 0; i < q.size() * 16; i++) begin
      @(negedge clk);
      total++;
      if ((sel != 0 ? b_txd : a_txd) !== q[i / 16]) begin
        bad++;
        $display("FAIL tx_bit: dut=%0d data=%h cyc=%0d txd=%b required %b", sel, d, i, sel != 0 ? b_txd : a_txd, q[i / 16]);
      end
      total++;
      if ((sel != 0 ? b_tready : a_tready) !== 1'b0) begin
        bad++;
        $display("FAIL tx_busy: dut=%0d cyc=%0d tready=%b required 0", sel, i, sel != 0 ? b_tready : a_tready);
      end
    end
    @(negedge clk);
    total++;
    if ((sel != 0 ? b_tready : a_tready) !== 1'b1 || (sel != 0 ? b_txd : a_txd) !== 1'b1) begin
      bad++;
      $display("FAIL tx_end: dut=%0d tready=%b txd=%b required 1 1", sel, sel != 0 ? b_tready : a_tready, sel != 0 ? b_txd : a_txd);
    end
  endtask

  task automatic set_rxd(input int sel, input logic v);
    if (sel != 0) c_rxd = v;
    else a_rxd = v;
  endtask

  // sel 0 = 8N1 instance, sel 1 = 8O1 instance; gb = bit index receiving a one-clock glitch
  task automatic rx_frame(input int sel, input logic [7:0] d, input logic flip, input logic stop0, input int gb);
    logic q[$];
    q.push_back(1'b0);
    for (int j = 0; j < 8; j++) q.push_back(d[j]);
    if (sel != 0) q.push_back(par_bit({1'b0, d}, 8, 2) ^ flip);
    q.push_back(!stop0);
    q.push_back(1'b1);
    for (int i = 0; i < q.size(); i++)
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        set_rxd(sel, (i == gb && k == 9) ? ~q[i] : q[i]);
      end
  endtask

  task automatic rx_expect(input int sel, input logic [7:0] d, input logic [2:0] u);
    total++;
    if ((sel != 0 ? c_rvalid : a_rvalid) !== 1'b1) begin bad++; $display("FAIL rx_valid: dut=%0d tvalid=%b required 1", sel, sel != 0 ? c_rvalid : a_rvalid); end
    total++;
    if ((sel != 0 ? c_rdata : a_rdata) !== d) begin bad++; $display("FAIL rx_data: dut=%0d tdata=%h required %h", sel, sel != 0 ? c_rdata : a_rdata, d); end
    total++;
    if ((sel != 0 ? c_ruser : a_ruser) !== u) begin bad++; $display("FAIL rx_user: dut=%0d tuser=%b required %b", sel, sel != 0 ? c_ruser : a_ruser, u); end
  endtask

  task automatic rx_consume(input int sel);
    @(negedge clk);
    if (sel != 0) c_rready = 1'b1; else a_rready = 1'b1;
    @(negedge clk);
    c_rready = 1'b0;
    a_rready = 1'b0;
    total++;
    if ((sel != 0 ? c_rvalid : a_rvalid) !== 1'b0) begin bad++; $display("FAIL rx_consume: dut=%0d tvalid=%b required 0", sel, sel != 0 ? c_rvalid : a_rvalid); end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (a_txd !== 1'b1 || b_txd !== 1'b1) begin bad++; $display("FAIL reset_txd: txd=%b%b required 11", a_txd, b_txd); end
    total++;
    if (a_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: tready=%b required 0", a_tready); end
    total++;
    if (a_rvalid !== 1'b0 || a_rdata !== 8'h00 || a_ruser !== 3'b000 || c_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_rx: tvalid=%b tdata=%h tuser=%b required 0 00 000", a_rvalid, a_rdata, a_ruser);
    end
    aresetn = 1'b1;
    #1;
    total++;
    if (a_tready !== 1'b0) begin bad++; $display("FAIL reset_release: tready=%b required 0", a_tready); end
    @(posedge clk);
    #1;
    total++;
    if (a_tready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise: tready=%b required 1", a_tready); end
  endtask

  task automatic test_tx_8n1;
    test_tx(0, 9'h0A5);
    repeat (2) test_tx(0, 9'($urandom));
  endtask

  task automatic test_tkeep;
    @(negedge clk);
    a_tkeep = 1'b0;
    a_tdata = 8'($urandom);
    a_tvalid = 1'b1;
    total++;
    if (a_tready !== 1'b1) begin bad++; $display("FAIL tkeep_ready: tready=%b required 1", a_tready); end
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    a_tkeep = 1'b1;
    repeat (32) begin
      @(negedge clk);
      total++;
      if (a_txd !== 1'b1 || a_tready !== 1'b1) begin bad++; $display("FAIL tkeep_idle: txd=%b tready=%b required 1 1", a_txd, a_tready); end
    end
  endtask

  task automatic test_loopback_7e2;
    logic [8:0] d;
    for (int i = 0; i < 4; i++) begin
      d = i == 0 ? 9'h055 : 9'($urandom);
      test_tx(1, d);
      total++;
      if (b_rvalid !== 1'b1 || b_rdata !== d[6:0] || b_ruser !== 3'b000) begin
        bad++;
        $display("FAIL loopback: tvalid=%b tdata=%h tuser=%b required 1 %h 000", b_rvalid, b_rdata, b_ruser, d[6:0]);
      end
      @(negedge clk);
      b_rready = 1'b1;
      @(negedge clk);
      b_rready = 1'b0;
      total++;
      if (b_rvalid !== 1'b0) begin bad++; $display("FAIL loopback_consume: tvalid=%b required 0", b_rvalid); end
    end
  endtask

  task automatic test_parity_8o1;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      rx_frame(1, d, 1'b0, 1'b0, -1);
      rx_expect(1, d, 3'b000);
      rx_consume(1);
      d = 8'($urandom);
      rx_frame(1, d, 1'b1, 1'b0, -1);
      rx_expect(1, d, 3'b010);
      rx_consume(1);
      d = 8'($urandom);
      rx_frame(1, d, 1'b0, 1'b1, -1);
      rx_expect(1, d, 3'b001);
      rx_consume(1);
    end
    rx_frame(1, 8'h00, 1'b0, 1'b1, -1);
    rx_expect(1, 8'h00, 3'b001);
    rx_consume(1);
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    @(negedge clk);
    a_rxd = 1'b0;
    repeat (5) @(negedge clk);
    a_rxd = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (a_rvalid !== 1'b0) begin bad++; $display("FAIL false_start: tvalid=%b required 0", a_rvalid); end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      rx_frame(0, d, 1'b0, 1'b0, int'($urandom_range(1, 8)));
      rx_expect(0, d, 3'b000);
      rx_consume(0);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    rx_frame(0, 8'h11, 1'b0, 1'b0, -1);
    rx_expect(0, 8'h11, 3'b000);
    rx_frame(0, 8'h22, 1'b0, 1'b0, -1);
    rx_frame(0, 8'h33, 1'b0, 1'b0, -1);
    rx_expect(0, 8'h11, 3'b000);
    rx_consume(0);
    rx_frame(0, 8'h44, 1'b0, 1'b0, -1);
    rx_expect(0, 8'h44, 3'b100);
    rx_consume(0);
    d = 8'($urandom);
    rx_frame(0, d, 1'b0, 1'b0, -1);
    rx_expect(0, d, 3'b000);
    rx_consume(0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    rx_frame(0, 8'h5A, 1'b0, 1'b0, -1);
    rx_frame(0, 8'h3C, 1'b0, 1'b0, -1);
    @(negedge clk);
    a_tdata = 8'h00;
    a_tkeep = 1'b1;
    a_tvalid = 1'b1;
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if (a_txd !== 1'b0 || a_tready !== 1'b0) begin bad++; $display("FAIL mid_frame: txd=%b tready=%b required 0 0", a_txd, a_tready); end
    @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if (a_txd !== 1'b1 || a_tready !== 1'b0) begin bad++; $display("FAIL async_reset: txd=%b tready=%b required 1 0", a_txd, a_tready); end
    total++;
    if (a_rvalid !== 1'b0) begin bad++; $display("FAIL reset_discard: tvalid=%b required 0", a_rvalid); end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (a_tready !== 1'b1) begin bad++; $display("FAIL reset_resume: tready=%b required 1", a_tready); end
    test_tx(0, 9'($urandom));
    d = 8'($urandom);
    rx_frame(0, d, 1'b0, 1'b0, -1);
    rx_expect(0, d, 3'b000);
    rx_consume(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx_8n1();
    test_tkeep();
    test_loopback_7e2();
    test_parity_8o1();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
